// File: rtl/reg_bank_arbiter_if.sv
// Request/grant bus between NREQ requesters and the shared register bank.
// Ports: req/we/addr/wdata/clr from requesters; gnt/rvalid/rdata/rid/busy back.
interface reg_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int IDW  = 2,
  parameter int W    = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0]  wdata;
  logic               clr;
  logic [NREQ-1:0]    gnt;
  logic               rvalid;
  logic [W-1:0]       rdata;
  logic [IDW-1:0]     rid;
  logic               busy;

  modport master (
    output req, we, addr, wdata, clr,
    input  gnt, rvalid, rdata, rid, busy
  );

  modport slave (
    input  req, we, addr, wdata, clr,
    output gnt, rvalid, rdata, rid, busy
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated bank of NREG W-bit registers, ARB/EXEC sequencing.
// Ports: clk, rst (sync, active-high), bus (slave side of reg_bank_arbiter_if).
module reg_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int IDW  = 2,
  parameter int W    = 16
) (
  input logic               clk,
  input logic               rst,
  reg_bank_arbiter_if.slave bus
);

  typedef enum logic {ARB, EXEC} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           win_we;
  logic [AW-1:0]  win_addr;
  logic [W-1:0]   win_wdata;
  logic [W-1:0]   regs [NREG];

  logic           rvalid_q;
  logic [W-1:0]   rdata_q;
  logic [IDW-1:0] rid_q;

  logic           any;
  logic [IDW-1:0] pick;
  logic           live;
  logic           in_range;
  logic [NREQ-1:0] gnt_c;

  function automatic logic [IDW-1:0] nxt(
    input logic [IDW-1:0] p,
    input int             k
  );
    return IDW'((int'(p) + k) % NREQ);
  endfunction

  // Scan from the far end so the entry closest to ptr+1 wins.
  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[nxt(ptr, k)]) begin
        any  = 1'b1;
        pick = nxt(ptr, k);
      end
    end
  end

  // A winner that dropped req, or a reset, kills the transaction.
  assign live     = (state == EXEC) && bus.req[win] && !rst;
  assign in_range = int'(win_addr) < NREG;

  always_comb begin
    gnt_c = '0;
    if (live) gnt_c[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      ptr       <= IDW'(NREQ - 1);
      win       <= '0;
      win_we    <= 1'b0;
      win_addr  <= '0;
      win_wdata <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (bus.clr) begin
        for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end
      unique case (state)
        ARB: begin
          if (any) begin
            state     <= EXEC;
            win       <= pick;
            win_we    <= bus.we[pick];
            win_addr  <= bus.addr[int'(pick)*AW +: AW];
            win_wdata <= bus.wdata[int'(pick)*W +: W];
          end
        end
        EXEC: begin
          state <= ARB;
          if (live) begin
            ptr <= win;
            if (win_we) begin
              if (in_range && !bus.clr) regs[win_addr] <= win_wdata;
            end else begin
              rvalid_q <= 1'b1;
              rid_q    <= win;
              rdata_q  <= (in_range && !bus.clr) ? regs[win_addr] : '0;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rid    = rid_q;
  assign bus.busy   = (state == EXEC);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios then random traffic.
// Reference model tracks register contents and round-robin pointer abstractly.
module tb_reg_bank_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int IDW  = 2;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.NREQ(NREQ), .AW(AW), .IDW(IDW), .W(W)) bus ();

  reg_bank_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .IDW(IDW), .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_mem [8];
  int           m_ptr;
  bit           ex_rv;
  logic [W-1:0] ex_rd;
  int           ex_id;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_ptr = NREQ - 1;
    ex_rv = 1'b0;
    ex_rd = '0;
    ex_id = 0;
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_op(int i, bit w, int a, logic [W-1:0] d);
    bus.req[i]           = 1'b1;
    bus.we[i]            = w;
    bus.addr[i*AW +: AW] = AW'(a);
    bus.wdata[i*W +: W]  = d;
  endtask

  // Negedge of an ARB cycle: idle outputs plus the pending read result.
  task automatic arb_check();
    @(negedge clk);
    check("busy_arb", 32'(bus.busy), 0);
    check("gnt_arb", 32'(bus.gnt), 0);
    check("rvalid", 32'(bus.rvalid), 32'(ex_rv));
    check("rdata", 32'(bus.rdata), 32'(ex_rd));
    check("rid", 32'(bus.rid), ex_id);
    ex_rv = 1'b0;
  endtask

  task automatic idle();
    arb_check();
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 with the DUT in ARB; returns at posedge+1 in ARB.
  task automatic step_exec(int w, bit clr_now, bit drop);
    int a;
    arb_check();
    @(posedge clk); #1;
    bus.clr = clr_now;
    @(negedge clk);
    check("busy_exec", 32'(bus.busy), 1);
    check("gnt_exec", 32'(bus.gnt), 32'(1) << w);
    @(posedge clk); #1;
    bus.clr = 1'b0;
    a = int'(bus.addr[w*AW +: AW]);
    if (bus.we[w]) begin
      if (!clr_now && a < NREG) m_mem[a] = bus.wdata[w*W +: W];
    end else begin
      ex_rv = 1'b1;
      ex_id = w;
      ex_rd = (clr_now || a >= NREG) ? '0 : m_mem[a];
    end
    if (clr_now) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
    end
    m_ptr = w;
    if (drop) bus.req[w] = 1'b0;
  endtask

  task automatic step_abort(int w);
    arb_check();
    @(posedge clk); #1;
    bus.req[w] = 1'b0;
    @(negedge clk);
    check("busy_abort", 32'(bus.busy), 1);
    check("gnt_abort", 32'(bus.gnt), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.clr   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_rid", 32'(bus.rid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int w;
    model_reset();
    do_reset();

    // 1: every address reads back zero to requester 0
    for (int a = 0; a < 8; a++) begin
      set_op(0, 1'b0, a, '0);
      step_exec(0, 1'b0, 1'b1);
    end
    idle();

    // 2: write then read back through requester 1
    set_op(1, 1'b1, 5, 16'hBEEF);
    step_exec(1, 1'b0, 1'b1);
    set_op(1, 1'b0, 5, '0);
    step_exec(1, 1'b0, 1'b1);
    idle();
    check("t2_rdata", 32'(bus.rdata), 32'h0000_BEEF);
    check("t2_rid", 32'(bus.rid), 1);

    // 3: all four held, round-robin order 0,1,2,3,0,1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 1'b1, i, 16'h1000 + 16'(i));
    for (int k = 0; k < 6; k++) step_exec(k % NREQ, 1'b0, 1'b0);
    bus.req = '0;
    idle();

    // 4: requester 2 aborts; pointer must stay at 1
    set_op(2, 1'b1, 4, 16'h5555);
    step_abort(2);
    set_op(3, 1'b0, 4, '0);
    set_op(2, 1'b0, 4, '0);
    step_exec(2, 1'b0, 1'b1);
    step_exec(3, 1'b0, 1'b1);
    idle();
    check("t4_rdata", 32'(bus.rdata), 0);

    // 5: clear during a write's EXEC wins over the write
    set_op(0, 1'b1, 2, 16'h1234);
    step_exec(0, 1'b1, 1'b1);
    set_op(0, 1'b0, 2, '0);
    step_exec(0, 1'b0, 1'b1);
    idle();
    check("t5_rdata", 32'(bus.rdata), 0);

    // 6: reset during EXEC aborts the write and restores priority
    set_op(1, 1'b1, 3, 16'h7777);
    step_exec(1, 1'b0, 1'b1);
    set_op(0, 1'b1, 1, 16'hAAAA);
    arb_check();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_gnt", 32'(bus.gnt), 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    bus.req = '0;
    model_reset();
    set_op(0, 1'b0, 1, '0);
    set_op(1, 1'b0, 3, '0);
    step_exec(0, 1'b0, 1'b1);
    step_exec(1, 1'b0, 1'b1);
    idle();
    check("t6_rdata", 32'(bus.rdata), 0);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && $urandom_range(0, 1) == 1)
          set_op(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 16'($urandom));
      end
      if (bus.req == '0)
        set_op($urandom_range(0, NREQ - 1), 1'b1, $urandom_range(0, 7),
               16'($urandom));
      w = model_pick();
      step_exec(w, $urandom_range(0, 9) == 0, 1'b1);
    end
    bus.req = '0;
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
